// File: rtl/iec_sd_arbiter_if.sv
// ---------------------------------------------------------------------------
// iec_sd_arbiter_if
// Bundles the per-drive request side and the host block-device channel of the
// multi-drive IEC arbiter.
//   Drive side : drv_lba[NDR], drv_rd, drv_wr, drv_buff_din[NDR] (to arbiter),
//                drv_ack (from arbiter)
//   Host side  : sd_lba, sd_rd, sd_wr, sd_buff_din (from arbiter),
//                sd_ack, sd_buff_wr (to arbiter)
//   Status     : busy, grant, xfer_cnt (from arbiter)
// Modports: slave = arbiter view, master = surrounding system view.
// ---------------------------------------------------------------------------
interface iec_sd_arbiter_if #(
    parameter int NDR = 2
);
    logic [31:0]    drv_lba      [NDR];
    logic [NDR-1:0] drv_rd;
    logic [NDR-1:0] drv_wr;
    logic [NDR-1:0] drv_ack;
    logic [7:0]     drv_buff_din [NDR];

    logic [31:0]    sd_lba;
    logic           sd_rd;
    logic           sd_wr;
    logic           sd_ack;
    logic [7:0]     sd_buff_din;
    logic           sd_buff_wr;

    logic           busy;
    logic [1:0]     grant;
    logic [9:0]     xfer_cnt;

    modport slave (
        input  drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
        output drv_ack, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant, xfer_cnt
    );

    modport master (
        output drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
        input  drv_ack, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant, xfer_cnt
    );
endinterface

// File: rtl/iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// iec_sd_arbiter
// Round-robin arbiter serialising per-drive block-device requests of a
// multi-drive IEC unit onto the single host block-device channel.
//   clk_sys : system clock, all logic on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : iec_sd_arbiter_if.slave (drive requests, host channel, status)
// One drive owns the host channel per transfer; ack and write data are routed
// to/from the granted drive only. A one-cycle GAP after each transfer keeps
// sd_rd/sd_wr low for at least one cycle between host requests.
// ---------------------------------------------------------------------------
module iec_sd_arbiter #(
    parameter int NDR = 2
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    iec_sd_arbiter_if.slave  bus
);
    localparam int unsigned NDRU = NDR;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t      state;
    logic [1:0]  last;

    logic        hit;
    logic [1:0]  pick;
    logic [31:0] pick_lba;
    logic        pick_rd;
    logic        pick_wr;
    logic        own_req;
    int unsigned best;

    // Distance of drive idx from the search start (last+1) in rotation order.
    function automatic int unsigned rr_dist(input int unsigned idx, input logic [1:0] from);
        return (idx + NDRU - 1 - 32'(from)) % NDRU;
    endfunction

    // Rotating-priority search: the requester closest to last+1 wins.
    always_comb begin
        hit      = 1'b0;
        pick     = '0;
        pick_lba = '0;
        pick_rd  = 1'b0;
        pick_wr  = 1'b0;
        best     = NDRU;
        for (int unsigned i = 0; i < NDRU; i++) begin
            if ((bus.drv_rd[i] | bus.drv_wr[i]) && (rr_dist(i, last) < best)) begin
                best     = rr_dist(i, last);
                hit      = 1'b1;
                pick     = 2'(i);
                pick_lba = bus.drv_lba[i];
                pick_rd  = bus.drv_rd[i];
                pick_wr  = bus.drv_wr[i] & ~bus.drv_rd[i];
            end
        end
    end

    // Granted drive still requesting, plus ack / write-data routing.
    always_comb begin
        own_req         = 1'b0;
        bus.drv_ack     = '0;
        bus.sd_buff_din = 8'hFF;
        for (int unsigned i = 0; i < NDRU; i++) begin
            if (bus.grant == 2'(i)) begin
                own_req        = bus.drv_rd[i] | bus.drv_wr[i];
                bus.drv_ack[i] = bus.sd_ack & bus.busy;
                if (bus.busy) begin
                    bus.sd_buff_din = bus.drv_buff_din[i];
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= IDLE;
            bus.sd_rd    <= 1'b0;
            bus.sd_wr    <= 1'b0;
            bus.sd_lba   <= '0;
            bus.busy     <= 1'b0;
            bus.grant    <= '0;
            bus.xfer_cnt <= '0;
            last         <= 2'(NDR - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        bus.grant    <= pick;
                        bus.sd_lba   <= pick_lba;
                        bus.sd_rd    <= pick_rd;
                        bus.sd_wr    <= pick_wr;
                        bus.xfer_cnt <= '0;
                        bus.busy     <= 1'b1;
                        last         <= pick;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        bus.sd_rd <= 1'b0;
                        bus.sd_wr <= 1'b0;
                        state     <= XFER;
                    end else if (!own_req) begin
                        // Drive withdrew before the host answered; last keeps it.
                        bus.sd_rd <= 1'b0;
                        bus.sd_wr <= 1'b0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                XFER: begin
                    if (bus.sd_buff_wr && (bus.xfer_cnt != '1)) begin
                        bus.xfer_cnt <= bus.xfer_cnt + 10'd1;
                    end
                    if (!bus.sd_ack) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iec_sd_arbiter
// Self-checking bench for iec_sd_arbiter with four drives: a table of grant
// vectors from reset, directed multi-cycle sequences, and a randomized run
// against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_iec_sd_arbiter;
    localparam int NDR = 4;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    iec_sd_arbiter_if #(.NDR(NDR)) bus();
    iec_sd_arbiter #(.NDR(NDR)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.drv_rd     = '0;
        bus.drv_wr     = '0;
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b0;
        for (int i = 0; i < NDR; i++) begin
            bus.drv_lba[i]      = 32'h1000 + 32'(i);
            bus.drv_buff_din[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sd_rd"}, 32'(bus.sd_rd), 0);
        chk({tag, "_sd_wr"}, 32'(bus.sd_wr), 0);
        chk({tag, "_sd_lba"}, bus.sd_lba, 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_xfer_cnt"}, 32'(bus.xfer_cnt), 0);
        chk({tag, "_drv_ack"}, 32'(bus.drv_ack), 0);
        chk({tag, "_buff_din"}, 32'(bus.sd_buff_din), 32'hFF);
    endtask

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       e_busy;
        logic [1:0] e_grant;
        logic       e_rd;
        logic       e_wr;
    } vec_t;
    vec_t vecs [8];

    // Reference model state (transaction view of the channel owner).
    bit          m_owned, m_acked, m_cool;
    int          m_grant, m_last, m_cnt;
    logic        m_rd, m_wr;
    logic [31:0] m_lba;

    task automatic model_step();
        bit found;
        if (!reset_n) begin
            m_owned = 0; m_acked = 0; m_cool = 0;
            m_grant = 0; m_last = NDR - 1; m_cnt = 0;
            m_rd = 0; m_wr = 0; m_lba = 0;
        end else if (!m_owned) begin
            found = 0;
            for (int k = 1; k <= NDR; k++) begin
                int d;
                d = (m_last + k) % NDR;
                if (!found && (bus.drv_rd[d] || bus.drv_wr[d])) begin
                    found = 1;
                    m_owned = 1; m_acked = 0; m_cool = 0;
                    m_grant = d; m_last = d; m_cnt = 0;
                    m_lba = bus.drv_lba[d];
                    m_rd = bus.drv_rd[d];
                    m_wr = bus.drv_wr[d] && !bus.drv_rd[d];
                end
            end
        end else if (m_cool) begin
            m_owned = 0; m_cool = 0;
        end else if (!m_acked) begin
            if (bus.sd_ack) begin
                m_acked = 1; m_rd = 0; m_wr = 0;
            end else if (!bus.drv_rd[m_grant] && !bus.drv_wr[m_grant]) begin
                m_owned = 0; m_rd = 0; m_wr = 0;
            end
        end else begin
            if (bus.sd_buff_wr && m_cnt < 1023) m_cnt++;
            if (!bus.sd_ack) begin
                m_cool = 1; m_acked = 0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, w, good, bad;
        logic [3:0] ea;
        logic [7:0] ed;
        int hold;

        vecs[0] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[2] = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[3] = '{4'b1010, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1};
        vecs[5] = '{4'b1000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{4'b1100, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};

        // Reset values, with a spurious host ack that must not reach any drive.
        idle_inputs();
        reset_n = 1'b0;
        bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk_reset_vals("rst");
        bus.sd_ack = 1'b0;

        // Grant vectors, each from reset (drive 0 searched first).
        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.drv_rd = vecs[v].rd;
            bus.drv_wr = vecs[v].wr;
            @(negedge clk_sys);
            chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vecs[v].e_busy));
            chk($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(vecs[v].e_grant));
            chk($sformatf("vec%0d_sd_rd", v), 32'(bus.sd_rd), 32'(vecs[v].e_rd));
            chk($sformatf("vec%0d_sd_wr", v), 32'(bus.sd_wr), 32'(vecs[v].e_wr));
            chk($sformatf("vec%0d_lba", v), bus.sd_lba,
                vecs[v].e_busy ? 32'h1000 + 32'(vecs[v].e_grant) : 32'h0);
            chk($sformatf("vec%0d_ack", v), 32'(bus.drv_ack), 0);
        end

        // Single read from drive 1: 600-cycle ack, 512 strobes.
        do_reset();
        bus.drv_lba[1] = 32'h1234;
        bus.drv_rd[1]  = 1'b1;
        @(negedge clk_sys);
        chk("sr_sd_rd", 32'(bus.sd_rd), 1);
        chk("sr_lba", bus.sd_lba, 32'h1234);
        chk("sr_grant", 32'(bus.grant), 1);
        good = 0; bad = 0;
        for (int j = 0; j < 600; j++) begin
            bus.sd_ack     = 1'b1;
            bus.sd_buff_wr = (j >= 1 && j <= 512);
            @(negedge clk_sys);
            if (j == 0) begin
                chk("sr_rd_fall", 32'(bus.sd_rd), 0);
                bus.drv_rd[1] = 1'b0;
            end
            if (bus.drv_ack == 4'b0010) good++; else bad++;
        end
        chk("sr_ack_cycles", good, 600);
        chk("sr_ack_wrong", bad, 0);
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        chk("sr_gap_busy", 32'(bus.busy), 1);
        chk("sr_gap_ack", 32'(bus.drv_ack), 0);
        chk("sr_xfer_cnt", 32'(bus.xfer_cnt), 512);
        @(negedge clk_sys);
        chk("sr_idle_busy", 32'(bus.busy), 0);
        chk("sr_cnt_hold", 32'(bus.xfer_cnt), 512);

        // Round robin with all four drives requesting reads.
        do_reset();
        bus.drv_rd = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            do begin
                @(negedge clk_sys);
                w++;
            end while (!bus.sd_rd && w < 20);
            chk("rr_wait", 32'(bus.sd_rd), 1);
            chk("rr_grant", 32'(bus.grant), 32'(t));
            chk("rr_lba", bus.sd_lba, 32'h1000 + 32'(t));
            chk("rr_spacing", w, (t == 0) ? 1 : 3);
            g = int'(bus.grant);
            bus.sd_ack = 1'b1;
            @(negedge clk_sys);
            chk("rr_ack", 32'(bus.drv_ack), 32'(1) << t);
            bus.drv_rd[g] = 1'b0;
            repeat (3) @(negedge clk_sys);
            bus.sd_ack = 1'b0;
        end
        repeat (2) @(negedge clk_sys);
        chk("rr_done_busy", 32'(bus.busy), 0);

        // Write mux from drive 2.
        do_reset();
        bus.drv_buff_din[2] = 8'hA5;
        bus.drv_wr[2] = 1'b1;
        @(negedge clk_sys);
        chk("wm_sd_wr", 32'(bus.sd_wr), 1);
        chk("wm_sd_rd", 32'(bus.sd_rd), 0);
        bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        bus.drv_wr[2] = 1'b0;
        @(negedge clk_sys);
        chk("wm_din_xfer", 32'(bus.sd_buff_din), 32'hA5);
        chk("wm_ack", 32'(bus.drv_ack), 32'b0100);
        bus.sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("wm_din_idle", 32'(bus.sd_buff_din), 32'hFF);

        // Abort before host ack, then a late ack pulse.
        do_reset();
        bus.drv_rd[0] = 1'b1;
        @(negedge clk_sys);
        chk("ab_sd_rd", 32'(bus.sd_rd), 1);
        bus.drv_rd[0] = 1'b0;
        @(negedge clk_sys);
        chk("ab_rd_fall", 32'(bus.sd_rd), 0);
        chk("ab_busy", 32'(bus.busy), 0);
        bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        chk("ab_late_ack", 32'(bus.drv_ack), 0);
        chk("ab_late_busy", 32'(bus.busy), 0);
        bus.sd_ack = 1'b0;
        bus.drv_rd = 4'b0011;
        @(negedge clk_sys);
        chk("ab_next_grant", 32'(bus.grant), 1);

        // Reset during a transfer, then drive 0 wins first.
        do_reset();
        bus.drv_rd[3] = 1'b1;
        @(negedge clk_sys);
        bus.sd_ack = 1'b1;
        bus.sd_buff_wr = 1'b1;
        @(negedge clk_sys);
        bus.drv_rd[3] = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rx_cnt_pre", 32'(bus.xfer_cnt), 3);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk_reset_vals("rx");
        reset_n = 1'b1;
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        bus.drv_rd = 4'b1001;
        @(negedge clk_sys);
        chk("rx_grant0", 32'(bus.grant), 0);
        chk("rx_sd_rd", 32'(bus.sd_rd), 1);

        // xfer_cnt saturation.
        do_reset();
        bus.drv_wr[1] = 1'b1;
        @(negedge clk_sys);
        bus.drv_wr[1] = 1'b0;
        for (int j = 0; j < 1030; j++) begin
            bus.sd_ack = 1'b1;
            bus.sd_buff_wr = 1'b1;
            @(negedge clk_sys);
        end
        chk("sat_cnt", 32'(bus.xfer_cnt), 1023);
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Randomized run against the reference model.
        do_reset();
        model_step();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_sys);
            ea = (bus.sd_ack && m_owned) ? 4'(1 << m_grant) : 4'b0;
            ed = m_owned ? bus.drv_buff_din[m_grant] : 8'hFF;
            chk("rnd_sd_rd", 32'(bus.sd_rd), 32'(m_rd));
            chk("rnd_sd_wr", 32'(bus.sd_wr), 32'(m_wr));
            chk("rnd_busy", 32'(bus.busy), 32'(m_owned));
            chk("rnd_ack", 32'(bus.drv_ack), 32'(ea));
            chk("rnd_din", 32'(bus.sd_buff_din), 32'(ed));
            chk("rnd_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
            if (m_owned) begin
                chk("rnd_grant", 32'(bus.grant), 32'(m_grant));
                chk("rnd_lba", bus.sd_lba, m_lba);
            end
            for (int i = 0; i < NDR; i++) begin
                bus.drv_buff_din[i] = 8'($urandom);
                if (bus.drv_rd[i] || bus.drv_wr[i]) begin
                    if (ea[i] || $urandom_range(0, 99) == 0) begin
                        bus.drv_rd[i] = 1'b0;
                        bus.drv_wr[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0: bus.drv_rd[i] = 1'b1;
                        1: bus.drv_wr[i] = 1'b1;
                        default: begin bus.drv_rd[i] = 1'b1; bus.drv_wr[i] = 1'b1; end
                    endcase
                    bus.drv_lba[i] = $urandom;
                end
            end
            if (hold > 0) begin
                bus.sd_ack = 1'b1;
                bus.sd_buff_wr = 1'($urandom_range(0, 1));
                hold--;
            end else begin
                bus.sd_ack = ($urandom_range(0, 31) == 0);
                bus.sd_buff_wr = 1'b0;
                if ((m_rd || m_wr) && $urandom_range(0, 2) == 0) hold = $urandom_range(1, 30);
            end
            reset_n = ($urandom_range(0, 499) != 0);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
